alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU directly downstream of the ALU controller.
- Consumes the 4-bit ALUOp and the negate control together with two register/immediate operands, and produces a registered result plus a zero flag.
- Logic/arithmetic/compare ops complete in one cycle. Shifts run on an iterative shifter to save area.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHIFT_STEP, 1, bit positions shifted per cycle in the iterative shifter; must be a power of two, 1 to WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- alu_op  input  4  operation code from the ALU controller.
- alu_negate  input  1  negate control from the ALU controller.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B; for shifts, B[log2(WIDTH)-1:0] is the shift amount.
- flush  input  1  synchronous abort of the current operation.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  high when result == 0; registered alongside result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Opcode table (alu_op -> result):
  - 0010 ADD
  - 0110 SUB
  - 0100 SLL
  - 0101 SLT, signed
  - 1000 SLTU
  - 0011 XOR
  - 0001 OR
  - 1001 AND
  - 1010 SRL
  - 1011 SRA
  - 0000 and all other codes: result 0, one-cycle latency, no error.
- Subtract select: sub = (alu_op==0110) | (alu_op==0010 & alu_negate). alu_negate is ignored for every other op.
- Arithmetic: ADD/SUB computed modulo 2^WIDTH; carry out is discarded.
- Compares: SLT and SLTU write 1 or 0 zero-extended to WIDTH.
- State machine: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE). It is combinational from state and is high during and after reset.
  - Accept = in_valid & in_ready at cycle t. Operands and op are captured at t; inputs are don't-care afterwards.
  - Non-shift op: IDLE -> DONE; out_valid=1 from cycle t+1.
  - Shift with amount n=0: IDLE -> DONE at t+1; result = op_a.
  - Shift with n>0: IDLE -> SHIFT. Each cycle shifts by min(SHIFT_STEP, remaining) and decrements the remaining count. SHIFT -> DONE when remaining reaches 0.
  - Shift latency: out_valid rises at t+1+ceil(n/SHIFT_STEP).
  - SRA fills vacated bits with the captured op_a[WIDTH-1]; SRL and SLL fill with 0.
  - DONE: result, zero and out_valid are held stable until out_valid & out_ready. On that cycle the FSM returns to IDLE and out_valid drops at the next edge.
  - No accept occurs in the cycle a result is consumed; minimum issue interval is 2 cycles.
- out_valid is never asserted in IDLE or SHIFT.
- result and zero change only on entry to DONE. Between operations they keep their last value; reset clears them.
- Flush (synchronous, any state):
  - Next state is IDLE; out_valid is 0 next cycle.
  - result and zero are unchanged and the pending result is dropped.
  - Flush wins over a simultaneous accept (the op is not captured) and over a simultaneous out_ready.
- Reset (asynchronous, any time, including mid-shift or mid-handshake):
  - state=IDLE, out_valid=0, result=0, zero=0, busy=0.
  - Remaining count and captured operands are cleared.
- Out-of-range shift amount cannot occur: only the low log2(WIDTH) bits of op_b are used.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 negate=0 -> out_valid at t+1, result=0x80000000, zero=0. Repeat with negate=1 -> result=0x7FFFFFFE.
- SUB a=5 b=5 -> result=0, zero=1. SLT a=0xFFFFFFFF b=1 -> result 1. SLTU with the same operands -> result 0. alu_op=0111 -> result 0, latency 1.
- SRA a=0x80000000 b=31, SHIFT_STEP=1 -> out_valid at t+32, result=0xFFFFFFFF, busy high t+1..t+32. SRL with the same operands -> 0x00000001. SLL by 0 -> result=a at t+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0 and in_valid ignored throughout. Raise out_ready -> IDLE next cycle, new op accepted the cycle after.
- flush during SHIFT (SLL by 20 at t+6) -> IDLE at t+7, no out_valid, result keeps previous value. flush with in_valid in IDLE -> op not captured.
- Assert reset asynchronously mid-shift, off clock edge -> out_valid, result, zero and busy go to 0 immediately and in_ready=1. Next op after deassertion executes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops and an
// iterative shifter, with valid/ready handshakes and one op in flight.
module alu_exec_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             alu_negate,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned CNT_W   = SHAMT_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  localparam logic [1:0] SK_SLL = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_d;

  logic [WIDTH-1:0]   shreg;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         kind;

  logic               sub_c;
  logic [WIDTH-1:0]   addsub_c;
  logic [WIDTH-1:0]   alu_c;
  logic               is_shift_c;
  logic [1:0]         kind_c;
  logic [SHAMT_W-1:0] shamt_c;

  logic [SHAMT_W-1:0] step_c;
  logic [SHAMT_W-1:0] rem_next_c;
  logic [WIDTH-1:0]   shifted_c;

  logic               load_shift;
  logic               shift_en;
  logic               load_result;
  logic [WIDTH-1:0]   result_d;

  // Handshake/status outputs decode straight from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Operation decode and single-cycle result for the accepting op.
  always_comb begin
    sub_c      = (alu_op == OP_SUB) | ((alu_op == OP_ADD) & alu_negate);
    addsub_c   = op_a + (sub_c ? ~op_b : op_b) + WIDTH'(sub_c);
    shamt_c    = op_b[SHAMT_W-1:0];
    is_shift_c = 1'b0;
    kind_c     = SK_SLL;
    alu_c      = '0;
    case (alu_op)
      OP_ADD,
      OP_SUB:  alu_c = addsub_c;
      OP_SLT:  alu_c = WIDTH'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_c = WIDTH'(op_a < op_b);
      OP_XOR:  alu_c = op_a ^ op_b;
      OP_OR:   alu_c = op_a | op_b;
      OP_AND:  alu_c = op_a & op_b;
      OP_SLL: begin
        is_shift_c = 1'b1;
        kind_c     = SK_SLL;
        alu_c      = op_a;
      end
      OP_SRL: begin
        is_shift_c = 1'b1;
        kind_c     = SK_SRL;
        alu_c      = op_a;
      end
      OP_SRA: begin
        is_shift_c = 1'b1;
        kind_c     = SK_SRA;
        alu_c      = op_a;
      end
      default: alu_c = '0;
    endcase
  end

  // One iteration of the shifter: move by min(SHIFT_STEP, remaining).
  always_comb begin
    if ({1'b0, rem} >= CNT_W'(SHIFT_STEP)) begin
      step_c = SHAMT_W'(SHIFT_STEP);
    end else begin
      step_c = rem;
    end
    rem_next_c = rem - step_c;
    case (kind)
      SK_SLL:  shifted_c = shreg << step_c;
      SK_SRL:  shifted_c = shreg >> step_c;
      default: shifted_c = $signed(shreg) >>> step_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath load enables; flush overrides everything.
  always_comb begin
    state_d     = state;
    load_shift  = 1'b0;
    shift_en    = 1'b0;
    load_result = 1'b0;
    result_d    = result;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          if (is_shift_c && (shamt_c != '0)) begin
            load_shift = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            load_result = 1'b1;
            result_d    = alu_c;
            state_d     = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          if (rem_next_c == '0) begin
            load_result = 1'b1;
            result_d    = shifted_c;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shifter operand/count registers and the held result/zero outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      rem    <= '0;
      kind   <= SK_SLL;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      if (load_shift) begin
        shreg <= op_a;
        rem   <= shamt_c;
        kind  <= kind_c;
      end else if (shift_en) begin
        shreg <= shifted_c;
        rem   <= rem_next_c;
      end else if (flush) begin
        rem <= '0;
      end
      if (load_result) begin
        result <= result_d;
        zero   <= (result_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;
  localparam int unsigned S = 1;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic         alu_negate;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W), .SHIFT_STEP(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_negate (alu_negate),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference result straight from the opcode table.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic neg,
                                             input logic [31:0] a, input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      4'b0010: return neg ? 32'(a - b) : 32'(a + b);
      4'b0110: return 32'(a - b);
      4'b0100: return a << n;
      4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      4'b0011: return a ^ b;
      4'b0001: return a | b;
      4'b1001: return a & b;
      4'b1010: return a >> n;
      4'b1011: return 32'($signed(a) >>> n);
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from accept until out_valid is visible.
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    if ((op == 4'b0100 || op == 4'b1010 || op == 4'b1011) && n > 0)
      return 1 + (n + int'(S) - 1) / int'(S);
    return 1;
  endfunction

  // Behavioural model: one op in flight, a countdown to its result.
  bit          m_inflight = 1'b0;
  int          m_wait     = 0;
  logic [31:0] m_pending  = '0;
  logic [31:0] m_result   = '0;
  logic        m_zero     = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inflight = 1'b0;
      m_wait     = 0;
      m_result   = '0;
      m_zero     = 1'b0;
    end else if (flush) begin
      m_inflight = 1'b0;
    end else if (!m_inflight) begin
      if (in_valid) begin
        m_inflight = 1'b1;
        m_pending  = ref_result(alu_op, alu_negate, op_a, op_b);
        m_wait     = ref_latency(alu_op, op_b) - 1;
        if (m_wait == 0) begin
          m_result = m_pending;
          m_zero   = (m_pending == 0);
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_result = m_pending;
        m_zero   = (m_pending == 0);
      end
    end else if (out_ready) begin
      m_inflight = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model in_ready",  32'(in_ready),  32'(!m_inflight));
    chk("model out_valid", 32'(out_valid), 32'(m_inflight && m_wait == 0));
    chk("model busy",      32'(busy),      32'(m_inflight));
    chk("model result",    result,         m_result);
    chk("model zero",      32'(zero),      32'(m_zero));
  end

  // Issue one op, wait for its result, check it against literals.
  task automatic do_op(input string name, input logic [3:0] op, input logic neg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input bit consume);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " ready"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    alu_op     = op;
    alu_negate = neg;
    op_a       = a;
    op_b       = b;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    alu_op     = 4'($urandom_range(0, 15));
    op_a       = $urandom;
    op_b       = $urandom;
    alu_negate = 1'($urandom_range(0, 1));
    chk({name, " busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " result"}, result, exp_res);
    chk({name, " zero"}, 32'(zero), 32'(exp_res == 0));
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    alu_op     = 4'd0;
    alu_negate = 1'b0;
    op_a       = '0;
    op_b       = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset result",    result,         32'd0);
    chk("reset zero",      32'(zero),      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed opcode cases.
    do_op("add",    4'b0010, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 1'b1);
    do_op("addneg", 4'b0010, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFE, 1, 1'b1);
    do_op("sub",    4'b0110, 1'b0, 32'd5, 32'd5, 32'd0, 1, 1'b1);
    do_op("slt",    4'b0101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b1);
    do_op("sltu",   4'b1000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);
    do_op("xor",    4'b0011, 1'b1, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1, 1'b1);
    do_op("op0111", 4'b0111, 1'b0, 32'h1234_5678, 32'd9, 32'd0, 1, 1'b1);
    do_op("sra31",  4'b1011, 1'b0, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 1'b1);
    do_op("srl31",  4'b1010, 1'b0, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 1'b1);
    do_op("sll0",   4'b0100, 1'b0, 32'hCAFE_0001, 32'hFFFF_FFE0, 32'hCAFE_0001, 1, 1'b1);
    do_op("sll3",   4'b0100, 1'b0, 32'h0000_0011, 32'd3, 32'h0000_0088, 4, 1'b1);

    // Backpressure: result held, new requests ignored until consumed.
    do_op("bp", 4'b0010, 1'b0, 32'd100, 32'd23, 32'd123, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      alu_op   = 4'b0011;
      op_a     = $urandom;
      op_b     = $urandom;
      chk("bp hold result",    result,          32'd123);
      chk("bp hold in_ready",  32'(in_ready),   32'd0);
      chk("bp hold out_valid", 32'(out_valid),  32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    alu_op     = 4'b0010;
    alu_negate = 1'b0;
    op_a       = 32'd1;
    op_b       = 32'd1;
    chk("bp release in_ready",  32'(in_ready),  32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release result",    result,         32'd123);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next out_valid", 32'(out_valid), 32'd1);
    chk("bp next result",    result,         32'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush mid-shift: op dropped, previous result kept.
    in_valid = 1'b1;
    alu_op   = 4'b0100;
    op_a     = 32'd1;
    op_b     = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready",  32'(in_ready),  32'd1);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush busy",      32'(busy),      32'd0);
    chk("flush result",    result,         32'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("flush later out_valid", 32'(out_valid), 32'd0);

    // Flush beats a simultaneous accept.
    in_valid = 1'b1;
    flush    = 1'b1;
    alu_op   = 4'b0001;
    op_a     = 32'h55;
    op_b     = 32'hAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush accept in_ready",  32'(in_ready),  32'd1);
    chk("flush accept busy",      32'(busy),      32'd0);
    chk("flush accept out_valid", 32'(out_valid), 32'd0);
    chk("flush accept result",    result,         32'd2);

    // Asynchronous reset mid-shift, between clock edges.
    in_valid = 1'b1;
    alu_op   = 4'b1011;
    op_a     = 32'h8000_0000;
    op_b     = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("areset in_ready",  32'(in_ready),  32'd1);
    chk("areset out_valid", 32'(out_valid), 32'd0);
    chk("areset busy",      32'(busy),      32'd0);
    chk("areset result",    result,         32'd0);
    chk("areset zero",      32'(zero),      32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    do_op("post reset add", 4'b0010, 1'b0, 32'd3, 32'd4, 32'd7, 1, 1'b1);
    do_op("post reset sra", 4'b1011, 1'b0, 32'hF000_0000, 32'd4, 32'hFF00_0000, 5, 1'b1);

    // Randomized traffic, checked only by the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 29) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      alu_op     = 4'($urandom_range(0, 15));
      alu_negate = 1'($urandom_range(0, 1));
      op_a       = $urandom;
      op_b       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 9) == 0) op_b = op_a;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
